// File: rtl/core_memory_responder.sv
// Single-port memory responder for the core: loads a program image over a
// valid/ready stream after reset, then serves core reads/writes with one-cycle latency.
module core_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter bit SKIP_LOAD  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           to_mem_addr,
  input  logic [15:0]           core_to_mem_data,
  input  logic                  core_to_mem_write_enable,
  output logic [15:0]           data_from_memory,
  output logic                  core_stall,
  input  logic                  load_valid,
  input  logic [15:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = SKIP_LOAD ? S_RUN : S_LOAD;

  state_t                r_state;
  state_t                w_next_state;
  logic [15:0]           r_mem [0:DEPTH-1];
  logic [15:0]           r_rd_data;
  logic [ADDR_WIDTH:0]   r_load_count;

  logic                  w_load_fire;
  logic                  w_in_range;
  logic                  w_core_wr;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [15:0]           w_wr_data;

  assign w_in_range = (to_mem_addr[15:ADDR_WIDTH] == '0);

  // Loader handshake: a word transfers on any edge where load_valid and
  // load_ready are both high; load_ready depends only on state, never on load_valid.
  always_comb begin
    w_next_state = r_state;
    load_ready   = 1'b0;
    core_stall   = 1'b0;
    w_load_fire  = 1'b0;
    w_core_wr    = 1'b0;
    if (r_state == S_LOAD) begin
      load_ready  = 1'b1;
      core_stall  = 1'b1;
      w_load_fire = load_valid;
      if (load_valid && (load_last || (r_load_count == LAST_IDX))) begin
        w_next_state = S_RUN;
      end
    end else begin
      w_core_wr = core_to_mem_write_enable & w_in_range;
    end
  end

  // Single write port shared by the loader and the core; they are never active together.
  always_comb begin
    w_wr_en   = w_load_fire | w_core_wr;
    w_wr_addr = to_mem_addr[ADDR_WIDTH-1:0];
    w_wr_data = core_to_mem_data;
    if (w_load_fire) begin
      w_wr_addr = r_load_count[ADDR_WIDTH-1:0];
      w_wr_data = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RESET_STATE;
      r_load_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load_fire) begin
        r_load_count <= r_load_count + 1'b1;
      end
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Registered read with explicit write-first bypass for same-address writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (r_state == S_LOAD || !w_in_range) begin
      r_rd_data <= '0;
    end else if (w_core_wr) begin
      r_rd_data <= core_to_mem_data;
    end else begin
      r_rd_data <= r_mem[to_mem_addr[ADDR_WIDTH-1:0]];
    end
  end

  assign data_from_memory = r_rd_data;
  assign load_count       = r_load_count;

endmodule
